cache_ctrl: RTL and testbench
=============================

// Module: cache_ctrl
// PURPOSE
// Controller for the 2-way, write-back data cache array. Sits between the CPU memory stage and the
// cache array / main memory, and drives the array's load, store, edit and invalid controls.
// It handles lookups, dirty-victim write-back and 4-word line refill, then replays the access.
// PARAMETERS
// ADDR_BITS            32  byte address width
// TAG_BITS             23  tag field, addr[31:9]
// SET_INDEX_WIDTH       5  set index, addr[8:4]
// ELEMENT_WORDS         4  words per line
// ELEMENT_WORDS_WIDTH   2  word index, addr[3:2]
// PORTS
// clk            in   1   clock, all state changes on posedge
// rst            in   1   asynchronous, active-high reset
// cpu_en_r       in   1   CPU load request; held stable while cpu_stall=1
// cpu_en_w       in   1   CPU store request; held stable while cpu_stall=1; never set with cpu_en_r
// cpu_addr       in   32  CPU byte address
// cpu_u_b_h_w    in   3   RV32I width/sign code, passed unchanged to the array
// cpu_din        in   32  store data
// cpu_dout       out  32  load data; valid in the cycle cpu_stall falls for a load
// cpu_stall      out  1   combinational; 1 while a request is outstanding
// cache_addr     out  32  array address
// cache_load     out  1   array load
// cache_store    out  1   array store (refill one word)
// cache_edit     out  1   array edit (CPU write hit)
// cache_invalid  out  1   array invalidate; tied 0
// cache_u_b_h_w  out  3   array width code
// cache_din      out  32  array write data
// cache_dout     in   32  array read data (registered in the array, 1-cycle latency)
// cache_hit      in   1   array hit flag (registered)
// cache_valid    in   1   victim-way valid flag (registered)
// cache_dirty    in   1   victim-way dirty flag (registered)
// cache_tag      in   23  victim-way tag (registered)
// mem_cs         out  1   memory request; held with addr/we/din until mem_ack
// mem_we         out  1   1 = write beat
// mem_addr       out  32  word-aligned memory address
// mem_din        out  32  memory write data
// mem_dout       in   32  memory read data; valid when mem_ack=1
// mem_ack        in   1   one-cycle completion pulse for the current beat
// BEHAVIOUR
// Reset (async): state=IDLE, word_cnt=0, victim_tag=0, cpu_dout=0, all cache_* controls and mem_cs/mem_we=0.
//   Reset mid write-back or refill abandons the memory beat. Array contents are not touched.
// States: IDLE, LOOKUP, WB_RD, WB_WR, FILL, and an optional REPLAY step that reuses LOOKUP.
// IDLE:   on cpu_en_r|cpu_en_w, drive cache_addr=cpu_addr, cache_load=cpu_en_r, cache_edit=cpu_en_w,
//         cache_din=cpu_din; cpu_stall=1; go to LOOKUP. With no request, cpu_stall=0.
// LOOKUP: drive the same address and controls with load/edit=0, so a second edit is impossible.
//   hit:                    cpu_stall=0; cpu_dout=cache_dout for loads; go to IDLE. Hit latency is 2 cycles.
//   miss & valid & dirty:   latch victim_tag=cache_tag, word_cnt=0; go to WB_RD.
//   miss otherwise:         word_cnt=0; go to FILL.
// WB_RD:  cache_addr={cpu tag,index,word_cnt,2'b00} with load=0, so the array returns the victim word next cycle;
//         go to WB_WR.
// WB_WR:  hold cache_addr. mem_cs=1, mem_we=1, mem_addr={victim_tag,index,word_cnt,00}, mem_din=cache_dout.
//   On mem_ack: if word_cnt==3, word_cnt=0 and go to FILL; otherwise word_cnt+1 and go to WB_RD.
// FILL:   mem_cs=1, mem_we=0, mem_addr={cpu tag,index,word_cnt,00}.
//   On mem_ack: cache_store=1, cache_din=mem_dout, cache_addr=mem_addr, cache_u_b_h_w=3'b010.
//   If word_cnt==3, go to IDLE-replay: re-probe as in IDLE, then LOOKUP, which now hits. Otherwise word_cnt+1.
// word_cnt is 2 bits and wraps 3->0 only on the explicit transitions above. A way is chosen by the array's recent bit,
//   which stays constant across the 4 store beats, so all beats land in the same way.
// mem_ack outside WB_WR/FILL is ignored. mem_cs is never asserted in IDLE or LOOKUP.
// cpu_dout holds its last value when not updated.
// STRUCTURE
// Address field widths come from the shared addr_define.vh. State encodings (3-bit localparams)
// belong in a new shared cache_ctrl_define.vh.
// One sub-module is natural: mem_beat_port, which registers mem_cs/we/addr/din and drops cs on ack.
// TESTING
// Read miss, clean set, mem latency 3: 4 FILL beats, then replay hit, cpu_dout = memory word; stall length 4*(3+1)+2.
// Read hit after fill, LB at 0x...03 with byte 0x80: cpu_dout=0xFFFFFF80 (LBU: 0x00000080), stall 1 cycle.
// Write hit SH at addr[1]=1: array word upper half updated, dirty set; exactly one edit pulse, no mem_cs.
// Dirty-victim miss (two tags fill set 5, one dirtied): 4 WB beats at {victim_tag,5,0..3}, then 4 FILL beats.
// Async rst asserted mid-FILL beat 2: mem_cs=0 immediately, state IDLE, next request re-misses cleanly.
// mem_ack pulsed while IDLE: no state change, no cache_store.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the 2-way write-back cache controller: address field
// widths, controller state encoding and the line-word address builder.
package cache_ctrl_pkg;

    localparam int unsigned ADDR_BITS           = 32;
    localparam int unsigned TAG_BITS            = 23;
    localparam int unsigned SET_INDEX_WIDTH     = 5;
    localparam int unsigned ELEMENT_WORDS       = 4;
    localparam int unsigned ELEMENT_WORDS_WIDTH = 2;
    localparam int unsigned INDEX_LSB           = ELEMENT_WORDS_WIDTH + 2;

    localparam logic [ELEMENT_WORDS_WIDTH-1:0] LAST_WORD = ELEMENT_WORDS_WIDTH'(ELEMENT_WORDS - 1);
    localparam logic [2:0]                     WIDTH_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB_RD  = 3'd2,
        ST_WB_WR  = 3'd3,
        ST_FILL   = 3'd4
    } state_t;

    function automatic logic [ADDR_BITS-1:0] line_word_addr(
        input logic [TAG_BITS-1:0]            tag,
        input logic [SET_INDEX_WIDTH-1:0]     index,
        input logic [ELEMENT_WORDS_WIDTH-1:0] word
    );
        return {tag, index, word, 2'b00};
    endfunction

endpackage

// File: rtl/cache_ctrl_mem_beat_port.sv
// Registered single-beat memory request port: a start pulse launches a beat and
// holds cs/we/addr/din stable until the memory acknowledges it.
module cache_ctrl_mem_beat_port
    import cache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 beat_we,
    input  logic [ADDR_BITS-1:0] beat_addr,
    input  logic [31:0]          beat_din,
    input  logic                 ack,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_din
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
        end else if (start) begin
            mem_cs <= 1'b1;
            mem_we <= beat_we;
        end else if (ack) begin
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // Address and data only matter while cs is high, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            mem_addr <= beat_addr;
            mem_din  <= beat_din;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Controller for the 2-way write-back data cache: lookup, dirty-victim
// write-back, 4-word refill and replay of the stalled CPU access.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_en_r,
    input  logic                 cpu_en_w,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [2:0]           cpu_u_b_h_w,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic [31:0]          cache_dout,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout,
    input  logic                 mem_ack
);

    state_t                         state;
    logic [ELEMENT_WORDS_WIDTH-1:0] word_cnt;
    logic [TAG_BITS-1:0]            victim_tag;

    logic [TAG_BITS-1:0]        cpu_tag;
    logic [SET_INDEX_WIDTH-1:0] cpu_index;
    logic [ADDR_BITS-1:0]       line_addr;
    logic [ADDR_BITS-1:0]       victim_addr;
    logic                       ack_ok;
    logic                       request;
    logic                       dirty_victim;

    logic                 beat_start;
    logic                 beat_we;
    logic [ADDR_BITS-1:0] beat_addr;
    logic [31:0]          beat_din;

    assign cpu_tag       = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
    assign cpu_index     = cpu_addr[INDEX_LSB +: SET_INDEX_WIDTH];
    assign line_addr     = line_word_addr(cpu_tag, cpu_index, word_cnt);
    assign victim_addr   = line_word_addr(victim_tag, cpu_index, word_cnt);
    assign request       = cpu_en_r | cpu_en_w;
    assign dirty_victim  = cache_valid & cache_dirty;
    // Acks only count against a beat that is actually in flight.
    assign ack_ok        = mem_ack & mem_cs;
    assign cache_invalid = 1'b0;

    always_comb begin
        cache_addr    = cpu_addr;
        cache_load    = 1'b0;
        cache_store   = 1'b0;
        cache_edit    = 1'b0;
        cache_u_b_h_w = cpu_u_b_h_w;
        cache_din     = cpu_din;
        cpu_stall     = 1'b1;
        beat_start    = 1'b0;
        beat_we       = 1'b0;
        beat_addr     = line_addr;
        beat_din      = cache_dout;
        case (state)
            ST_IDLE: begin
                cache_load = cpu_en_r & ~rst;
                cache_edit = cpu_en_w & ~rst;
                cpu_stall  = request;
            end
            ST_LOOKUP: begin
                cpu_stall = ~cache_hit;
                // A clean miss launches the first refill beat straight away.
                if (!cache_hit && !dirty_victim) begin
                    beat_start = 1'b1;
                    beat_addr  = line_word_addr(cpu_tag, cpu_index, '0);
                end
            end
            ST_WB_RD: begin
                cache_addr = line_addr;
            end
            ST_WB_WR: begin
                cache_addr = line_addr;
                beat_start = ~mem_cs;
                beat_we    = 1'b1;
                beat_addr  = victim_addr;
            end
            ST_FILL: begin
                cache_addr = line_addr;
                beat_start = ~mem_cs;
                if (ack_ok) begin
                    cache_store   = 1'b1;
                    cache_din     = mem_dout;
                    cache_u_b_h_w = WIDTH_WORD;
                end
            end
            default: begin
                cpu_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            victim_tag <= '0;
            cpu_dout   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) state <= ST_LOOKUP;
                end
                ST_LOOKUP: begin
                    if (cache_hit) begin
                        if (cpu_en_r) cpu_dout <= cache_dout;
                        state <= ST_IDLE;
                    end else if (dirty_victim) begin
                        victim_tag <= cache_tag;
                        word_cnt   <= '0;
                        state      <= ST_WB_RD;
                    end else begin
                        word_cnt <= '0;
                        state    <= ST_FILL;
                    end
                end
                ST_WB_RD: begin
                    state <= ST_WB_WR;
                end
                ST_WB_WR: begin
                    if (ack_ok) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= ST_FILL;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                            state    <= ST_WB_RD;
                        end
                    end
                end
                ST_FILL: begin
                    // After the last word the held request is re-probed from IDLE and now hits.
                    if (ack_ok) begin
                        if (word_cnt == LAST_WORD) state <= ST_IDLE;
                        else word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    cache_ctrl_mem_beat_port u_beat (
        .clk       (clk),
        .rst       (rst),
        .start     (beat_start),
        .beat_we   (beat_we),
        .beat_addr (beat_addr),
        .beat_din  (beat_din),
        .ack       (ack_ok),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din)
    );

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural 2-way array and a
// fixed-latency word memory.
module tb_cache_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_en_r = 1'b0, cpu_en_w = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_din = '0;
    logic [2:0]  cpu_u_b_h_w = '0;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic [31:0] cache_addr, cache_din, cache_dout;
    logic        cache_load, cache_store, cache_edit, cache_invalid;
    logic [2:0]  cache_u_b_h_w;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [22:0] cache_tag;
    logic        mem_cs, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_din, mem_dout;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_en_r(cpu_en_r), .cpu_en_w(cpu_en_w), .cpu_addr(cpu_addr),
        .cpu_u_b_h_w(cpu_u_b_h_w), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_store(cache_store),
        .cache_edit(cache_edit), .cache_invalid(cache_invalid), .cache_u_b_h_w(cache_u_b_h_w),
        .cache_din(cache_din), .cache_dout(cache_dout), .cache_hit(cache_hit),
        .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    initial forever #5 clk = ~clk;

    // Array model: 32 sets x 2 ways x 4 words, registered outputs.
    logic [22:0] a_tag [32][2];
    bit          a_val [32][2];
    bit          a_dty [32][2];
    bit          a_rec [32];
    logic [31:0] a_dat [32][2][4];
    logic [4:0]  m_set;
    logic [1:0]  m_word;
    logic        m_hit, m_way;
    logic [31:0] m_raw;

    function automatic logic [31:0] fmt_load(input logic [31:0] wd, input logic [1:0] off, input logic [2:0] u);
        logic [7:0]  b;
        logic [15:0] h;
        b = wd[{off, 3'b000} +: 8];
        h = off[1] ? wd[31:16] : wd[15:0];
        case (u)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] wd, input logic [31:0] d, input logic [1:0] off, input logic [2:0] u);
        logic [31:0] r;
        r = wd;
        case (u[1:0])
            2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
            2'b01:   if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        m_set  = cache_addr[8:4];
        m_word = cache_addr[3:2];
        m_hit  = 1'b0;
        m_way  = 1'b0;
        if (a_val[m_set][0] && a_tag[m_set][0] == cache_addr[31:9]) begin
            m_hit = 1'b1; m_way = 1'b0;
        end else if (a_val[m_set][1] && a_tag[m_set][1] == cache_addr[31:9]) begin
            m_hit = 1'b1; m_way = 1'b1;
        end else if (!a_val[m_set][0]) m_way = 1'b0;
        else if (!a_val[m_set][1]) m_way = 1'b1;
        else m_way = ~a_rec[m_set];
        m_raw = a_dat[m_set][m_way][m_word];
    end

    always @(posedge clk) begin
        cache_hit   <= m_hit;
        cache_valid <= a_val[m_set][m_way];
        cache_dirty <= a_dty[m_set][m_way];
        cache_tag   <= a_tag[m_set][m_way];
        cache_dout  <= cache_load ? fmt_load(m_raw, cache_addr[1:0], cache_u_b_h_w) : m_raw;
        if ((cache_load || cache_edit) && m_hit) a_rec[m_set] <= m_way;
        if (cache_edit && m_hit) begin
            a_dat[m_set][m_way][m_word] <= st_merge(m_raw, cache_din, cache_addr[1:0], cache_u_b_h_w);
            a_dty[m_set][m_way] <= 1'b1;
        end
        if (cache_store) begin
            a_dat[m_set][m_way][m_word] <= cache_din;
            a_tag[m_set][m_way] <= cache_addr[31:9];
            a_val[m_set][m_way] <= (m_word == 2'd3);
            a_dty[m_set][m_way] <= 1'b0;
        end
    end

    // Memory model: ack in the LAT-th cycle of cs, plus activity counters.
    logic [31:0] wmem [1024];
    bit          wv [1024];
    logic        ack_m = 1'b0, ack_force = 1'b0;
    int          lat_cnt = 0, rd_n = 0, wr_n = 0, edit_n = 0, store_n = 0, cs_n = 0;
    logic [31:0] wlog_a [8], wlog_d [8];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'h8000_005A | ((a >> 2) << 8);
    endfunction

    assign mem_ack = ack_m | ack_force;

    always @(posedge clk) begin
        if (mem_cs && !ack_m) begin
            if (lat_cnt == LAT - 2) begin
                ack_m    <= 1'b1;
                lat_cnt  <= 0;
                mem_dout <= wv[mem_addr[11:2]] ? wmem[mem_addr[11:2]] : pat(mem_addr);
            end else lat_cnt <= lat_cnt + 1;
        end else begin
            ack_m   <= 1'b0;
            lat_cnt <= 0;
        end
        if (mem_cs && mem_ack) begin
            if (mem_we) begin
                wmem[mem_addr[11:2]] <= mem_din;
                wv[mem_addr[11:2]]   <= 1'b1;
                if (wr_n < 8) begin
                    wlog_a[wr_n] <= mem_addr;
                    wlog_d[wr_n] <= mem_din;
                end
                wr_n <= wr_n + 1;
            end else rd_n <= rd_n + 1;
        end
        if (cache_edit)  edit_n  <= edit_n + 1;
        if (cache_store) store_n <= store_n + 1;
        if (mem_cs)      cs_n    <= cs_n + 1;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns stalled cycles and load data.
    task automatic cpu_op(input logic rd, input logic [31:0] a, input logic [2:0] w,
                          input logic [31:0] d, output int stl, output logic [31:0] q);
        cpu_en_r = rd; cpu_en_w = ~rd; cpu_addr = a; cpu_u_b_h_w = w; cpu_din = d;
        stl = 0;
        #1;
        while (cpu_stall && stl < 300) begin
            stl++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        q = cpu_dout;
        cpu_en_r = 1'b0; cpu_en_w = 1'b0;
    endtask

    initial begin
        int stl, b_rd, b_wr, b_st, b_ed, b_cs, waited;
        logic [31:0] q;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_cs", {30'd0, mem_cs, mem_we}, 32'd0);
        chk("rst_dout", cpu_dout, 32'd0);
        chk("rst_ctl", {28'd0, cache_load, cache_store, cache_edit, cache_invalid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean read miss: 4 refill beats then replay hit.
        b_rd = rd_n; b_st = store_n;
        cpu_op(1'b1, 32'h0000_0254, 3'b010, 32'd0, stl, q);
        chk("miss_stall", stl, 18);
        chk("miss_data", q, 32'h8000_955A);
        chk("miss_rd_beats", rd_n - b_rd, 4);
        chk("miss_stores", store_n - b_st, 4);

        // Byte loads hit the freshly filled line.
        cpu_op(1'b1, 32'h0000_0253, 3'b000, 32'd0, stl, q);
        chk("lb_stall", stl, 1);
        chk("lb_data", q, 32'hFFFF_FF80);
        cpu_op(1'b1, 32'h0000_0253, 3'b100, 32'd0, stl, q);
        chk("lbu_stall", stl, 1);
        chk("lbu_data", q, 32'h0000_0080);

        // Store-half hit into the upper half.
        b_ed = edit_n; b_cs = cs_n;
        cpu_op(1'b0, 32'h0000_0252, 3'b001, 32'h0000_BEEF, stl, q);
        chk("sh_stall", stl, 1);
        chk("sh_edits", edit_n - b_ed, 1);
        chk("sh_no_cs", cs_n - b_cs, 0);
        chk("sh_dirty", {31'd0, a_dty[5][0]}, 32'd1);
        cpu_op(1'b1, 32'h0000_0250, 3'b010, 32'd0, stl, q);
        chk("sh_readback", q, 32'hBEEF_945A);

        // Second tag fills the other way of set 5.
        b_wr = wr_n;
        cpu_op(1'b1, 32'h0000_0450, 3'b010, 32'd0, stl, q);
        chk("fill_b_data", q, 32'h8001_145A);
        chk("fill_b_no_wb", wr_n - b_wr, 0);

        // Third tag evicts the dirty line: write-back then refill.
        b_wr = wr_n; b_rd = rd_n;
        cpu_op(1'b1, 32'h0000_0650, 3'b010, 32'd0, stl, q);
        chk("wb_beats", wr_n - b_wr, 4);
        chk("wb_fill_beats", rd_n - b_rd, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wb_addr%0d", i), wlog_a[b_wr + i], 32'h0000_0250 + 32'(4 * i));
        chk("wb_data0", wlog_d[b_wr], 32'hBEEF_945A);
        chk("wb_data3", wlog_d[b_wr + 3], 32'h8000_975A);
        chk("wb_miss_data", q, 32'h8001_945A);

        // Stray ack while idle.
        b_st = store_n;
        ack_force = 1'b1;
        @(posedge clk); #1;
        ack_force = 1'b0;
        @(posedge clk); #1;
        chk("idle_ack_store", store_n - b_st, 0);
        chk("idle_ack_stall", {31'd0, cpu_stall}, 32'd0);
        chk("idle_ack_cs", {31'd0, mem_cs}, 32'd0);
        cpu_op(1'b1, 32'h0000_0650, 3'b010, 32'd0, stl, q);
        chk("idle_ack_hit_stall", stl, 1);
        chk("idle_ack_hit_data", q, 32'h8001_945A);

        // Async reset during the third refill beat.
        b_rd = rd_n;
        cpu_en_r = 1'b1; cpu_addr = 32'h0000_0850; cpu_u_b_h_w = 3'b010;
        waited = 0;
        while (!(rd_n - b_rd == 2 && mem_cs) && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("rst_fill_reached", {31'd0, (waited < 200)}, 32'd1);
        #3;
        rst = 1'b1; cpu_en_r = 1'b0;
        #1;
        chk("rst_fill_cs", {31'd0, mem_cs}, 32'd0);
        chk("rst_fill_store", {31'd0, cache_store}, 32'd0);
        chk("rst_fill_stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        b_rd = rd_n;
        cpu_op(1'b1, 32'h0000_0850, 3'b010, 32'd0, stl, q);
        chk("refill_stall", stl, 18);
        chk("refill_data", q, 32'h8002_145A);
        chk("refill_beats", rd_n - b_rd, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
